// File: rtl/sample_pair_packer_pkg.sv
// Shared constants and types for the ADC sample-pair byte packer.
// Holds the sync header bytes, the FSM state encoding and the pair payload.
package sample_pair_packer_pkg;

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned PAIR_W   = 2 * SAMPLE_W;
    localparam int unsigned BYTE_W   = 8;

    localparam logic [BYTE_W-1:0] SYNC0 = 8'hA5;
    localparam logic [BYTE_W-1:0] SYNC1 = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_B0   = 3'd3,
        ST_B1   = 3'd4,
        ST_B2   = 3'd5
    } state_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] s1;
        logic [SAMPLE_W-1:0] s2;
    } pair_t;

endpackage

// File: rtl/sample_pair_packer_pair_fifo.sv
// Synchronous sample-pair FIFO with flop storage; dout always shows the head entry.
// Caller guarantees no pop when empty and no push when full unless popping too.
module sample_pair_packer_pair_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/sample_pair_packer.sv
// Buffers averaged ADC sample pairs and serialises them as a framed byte stream:
// sync header A5 5A, then FRAME_LEN pairs of 3 bytes each, with ready/valid backpressure.
module sample_pair_packer
    import sample_pair_packer_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FRAME_LEN = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [SAMPLE_W-1:0]     in1,
    input  logic [SAMPLE_W-1:0]     in2,
    output logic [BYTE_W-1:0]       byte_data,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic                    frame_start
);

    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    pair_cnt_q, pair_cnt_d;
    pair_t               hold_q, hold_d;
    logic [BYTE_W-1:0]   byte_data_q, byte_data_d;
    logic                byte_valid_q, byte_valid_d;
    logic                frame_start_q, frame_start_d;
    logic                overflow_q, overflow_d;

    logic                xfer_c;
    logic                pop_c;
    logic                push_c;
    logic [CNT_W-1:0]    cnt_next_c;
    pair_t               fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;

    sample_pair_packer_pair_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .din_i   ({in1, in2}),
        .dout_o  (fifo_dout),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign xfer_c     = byte_valid_q & byte_ready;
    assign cnt_next_c = (pair_cnt_q == CNT_W'(FRAME_LEN - 1)) ? '0 : pair_cnt_q + CNT_W'(1);
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_c     = in_valid & (~fifo_full | pop_c);

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = (pair_cnt_q == '0) ? ST_HDR0 : ST_B0;
            ST_HDR0: if (xfer_c) state_d = ST_HDR1;
            ST_HDR1: if (xfer_c) state_d = ST_B0;
            ST_B0:   if (xfer_c) state_d = ST_B1;
            ST_B1:   if (xfer_c) state_d = ST_B2;
            ST_B2: begin
                if (xfer_c) begin
                    if (fifo_empty)             state_d = ST_IDLE;
                    else if (cnt_next_c != '0)  state_d = ST_B0;
                    else                        state_d = ST_HDR0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the output/datapath registers; byte_data only changes on a state change.
    always_comb begin
        pop_c         = (state_d == ST_B0) && (state_q != ST_B0);
        hold_d        = pop_c ? fifo_dout : hold_q;
        pair_cnt_d    = ((state_q == ST_B2) && xfer_c) ? cnt_next_c : pair_cnt_q;
        byte_valid_d  = (state_d != ST_IDLE);
        frame_start_d = (state_q == ST_HDR0) && xfer_c;
        overflow_d    = overflow_q | (in_valid & ~push_c);
        byte_data_d   = byte_data_q;
        if (state_d != state_q) begin
            case (state_d)
                ST_HDR0: byte_data_d = SYNC0;
                ST_HDR1: byte_data_d = SYNC1;
                ST_B0:   byte_data_d = hold_d.s1[11:4];
                ST_B1:   byte_data_d = {hold_q.s1[3:0], hold_q.s2[11:8]};
                ST_B2:   byte_data_d = hold_q.s2[7:0];
                default: byte_data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pair_cnt_q    <= '0;
            hold_q        <= '0;
            byte_data_q   <= '0;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            pair_cnt_q    <= pair_cnt_d;
            hold_q        <= hold_d;
            byte_data_q   <= byte_data_d;
            byte_valid_q  <= byte_valid_d;
            frame_start_q <= frame_start_d;
            overflow_q    <= overflow_d;
        end
    end

    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign frame_start = frame_start_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sample_pair_packer.sv
// Self-checking bench for sample_pair_packer: table vectors, hand-timed corner
// sequences and a randomized run scored against a byte-stream model.
module tb_sample_pair_packer;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned FRAME_LEN = 2;
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic [11:0]       in1, in2;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
    logic              frame_start;

    sample_pair_packer #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in1         (in1),
        .in2         (in2),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  e2;
    } vec_t;

    vec_t        vecs [4];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ready_mode = 1;   // 0 low, 1 high, 2 toggle, 3 random
    logic [7:0]  got [$];
    int          got_cyc [$];
    int          fs_cnt = 0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [7:0]  exp_q [$];
    int          model_pairs = 0;
    int          model_hdrs = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive ready, observe this cycle's handshake, advance to next negedge.
    task automatic tick();
        case (ready_mode)
            0:       byte_ready = 1'b0;
            1:       byte_ready = 1'b1;
            2:       byte_ready = ~byte_ready;
            default: byte_ready = 1'($urandom_range(0, 1));
        endcase
        if (reset_n) begin
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", byte_valid, 1);
                chk("stall_data", byte_data, prev_data);
            end
            if (byte_valid && byte_ready) begin
                got.push_back(byte_data);
                got_cyc.push_back(cyc);
            end
            if (frame_start) fs_cnt++;
        end
        prev_valid = byte_valid;
        prev_ready = byte_ready;
        prev_data  = byte_data;
        @(negedge clk);
        cyc++;
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pairs = 0;
        model_hdrs  = 0;
    endtask

    task automatic model_header();
        if (model_pairs % FRAME_LEN == 0) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h5A);
            model_hdrs++;
        end
    endtask

    task automatic expect_vec(input int i);
        model_header();
        exp_q.push_back(vecs[i].e0);
        exp_q.push_back(vecs[i].e1);
        exp_q.push_back(vecs[i].e2);
        model_pairs++;
    endtask

    task automatic model_pair(input int unsigned a, input int unsigned b);
        model_header();
        exp_q.push_back(8'(a / 16));
        exp_q.push_back(8'((a % 16) * 16 + b / 256));
        exp_q.push_back(8'(b % 256));
        model_pairs++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, byte_valid, 0);
        chk({tag, "_data"}, byte_data, 0);
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_fs"}, frame_start, 0);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        got.delete();
        got_cyc.delete();
        fs_cnt = 0;
        prev_valid = 1'b0;
        model_reset();
    endtask

    task automatic push(input logic [11:0] a, input logic [11:0] b);
        in_valid = 1'b1;
        in1 = a;
        in2 = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (got.size() < n) chk({name, "_timeout"}, got.size(), n);
    endtask

    task automatic compare_stream(input string name);
        int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", name, i), got[i], exp_q[i]);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int pushed, completed, cycles;
        int last_idx [$];
        logic [11:0] ra, rb;

        vecs[0] = '{12'hABC, 12'h123, 8'hAB, 8'hC1, 8'h23};
        vecs[1] = '{12'h000, 12'hFFF, 8'h00, 8'h0F, 8'hFF};
        vecs[2] = '{12'hFFF, 12'h000, 8'hFF, 8'hF0, 8'h00};
        vecs[3] = '{12'h5A5, 12'hA5A, 8'h5A, 8'h5A, 8'h5A};

        reset_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; byte_ready = 1'b0;
        @(negedge clk);

        // Test 1: single pair, latency and idle afterwards
        do_reset();
        ready_mode = 1;
        push(vecs[0].a, vecs[0].b);
        chk("t1_lat_n1_valid", byte_valid, 0);
        tick();
        chk("t1_lat_n2_valid", byte_valid, 1);
        chk("t1_lat_n2_data", byte_data, 8'hA5);
        wait_bytes(5, 40, "t1");
        idle_ticks(4);
        expect_vec(0);
        compare_stream("t1");
        chk("t1_idle_valid", byte_valid, 0);
        chk("t1_frame_start", fs_cnt, 1);
        chk("t1_level", fifo_level, 0);

        // Test 2: table pairs across a frame boundary, one byte per clock
        do_reset();
        ready_mode = 1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in1 = vecs[i].a; in2 = vecs[i].b;
            tick();
            expect_vec(i);
        end
        in_valid = 1'b0;
        wait_bytes(13, 60, "t2");
        idle_ticks(4);
        compare_stream("t2");
        for (int i = 1; i < got_cyc.size(); i++)
            chk($sformatf("t2_gap%0d", i), got_cyc[i] - got_cyc[i-1], 1);
        chk("t2_frame_start", fs_cnt, 2);

        // Test 3: toggling backpressure
        do_reset();
        ready_mode = 2;
        push(vecs[0].a, vecs[0].b);
        expect_vec(0);
        wait_bytes(5, 60, "t3");
        idle_ticks(4);
        compare_stream("t3");

        // Test 4: overflow with sink stalled
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_valid = 1'b1; in1 = vecs[i % 4].a; in2 = vecs[i % 4].b;
            tick();
            if (i < DEPTH) expect_vec(i % 4);
        end
        in_valid = 1'b0;
        idle_ticks(3);
        chk("t4_level_full", fifo_level, DEPTH);
        chk("t4_overflow", overflow, 1);
        ready_mode = 1;
        wait_bytes(exp_q.size(), 80, "t4");
        idle_ticks(4);
        compare_stream("t4");
        chk("t4_overflow_sticky", overflow, 1);
        chk("t4_level_empty", fifo_level, 0);
        chk("t4_frame_start", fs_cnt, 2);

        // Test 5: push while full on the same edge as a pop
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in1 = vecs[i].a; in2 = vecs[i].b;
            tick();
            expect_vec(i);
        end
        in_valid = 1'b0;
        idle_ticks(2);
        chk("t5_level_full", fifo_level, DEPTH);
        chk("t5_ovf_before", overflow, 0);
        ready_mode = 1;
        tick();
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (byte_valid && byte_data == 8'h5A) found = 1;
            else tick();
        end
        chk("t5_found_hdr1", found, 1);
        in_valid = 1'b1; in1 = 12'h777; in2 = 12'h888;
        tick();
        in_valid = 1'b0;
        model_pair(12'h777, 12'h888);
        chk("t5_level_pushpop", fifo_level, DEPTH);
        chk("t5_ovf_after", overflow, 0);
        wait_bytes(exp_q.size(), 80, "t5");
        idle_ticks(4);
        compare_stream("t5");
        chk("t5_frame_start", fs_cnt, 3);

        // Test 6: reset after byte B1 of a pair
        do_reset();
        ready_mode = 1;
        push(vecs[0].a, vecs[0].b);
        wait_bytes(4, 40, "t6a");
        reset_n = 1'b0;
        tick();
        check_reset_outputs("t6_rst");
        reset_n = 1'b1;
        got.delete(); got_cyc.delete(); fs_cnt = 0; prev_valid = 1'b0;
        model_reset();
        tick();
        push(vecs[1].a, vecs[1].b);
        expect_vec(1);
        wait_bytes(5, 40, "t6");
        idle_ticks(4);
        compare_stream("t6");
        chk("t6_frame_start", fs_cnt, 1);

        // Test 7: randomized pairs and ready against the stream model
        do_reset();
        ready_mode = 3;
        pushed = 0; completed = 0; cycles = 0;
        while (pushed < 40 && cycles < 4000) begin
            if ($urandom_range(0, 2) == 0 && (pushed - completed) < DEPTH) begin
                ra = 12'($urandom); rb = 12'($urandom);
                in_valid = 1'b1; in1 = ra; in2 = rb;
                model_pair(ra, rb);
                last_idx.push_back(exp_q.size() - 1);
                pushed++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cycles++;
            while (completed < pushed && last_idx[completed] < got.size()) completed++;
        end
        in_valid = 1'b0;
        chk("t7_all_pushed", pushed, 40);
        wait_bytes(exp_q.size(), 2000, "t7");
        ready_mode = 1;
        idle_ticks(4);
        compare_stream("t7");
        chk("t7_overflow", overflow, 0);
        chk("t7_level", fifo_level, 0);
        chk("t7_idle_valid", byte_valid, 0);
        chk("t7_frame_start", fs_cnt, model_hdrs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
